// File: rtl/uart_tx_fifo.sv
// RS-232 transmitter with configurable framing and a word FIFO behind a valid/ready handshake.
// The line, busy and send_complete are registered one cycle behind the FSM so they stay aligned.
module uart_tx_fifo #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          rs232_tx,
    output logic                          busy,
    output logic                          send_complete,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state, state_nxt;
    logic [BAUD_W-1:0]    baud_cnt, baud_nxt;
    logic [BIT_W-1:0]     bit_cnt, bit_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic                 par_bit, par_nxt;
    logic                 line_c;
    logic                 done_c;
    logic                 pop;
    logic                 push;
    logic                 baud_end;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count_nxt;
    logic [DATA_BITS-1:0] rd_data;

    assign push     = tx_valid && tx_ready;
    assign rd_data  = mem[rd_ptr];
    assign baud_end = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));

    // Storage array: no reset needed, occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_comb begin
        count_nxt = fifo_count;
        if (push && !pop) begin
            count_nxt = fifo_count + CNT_W'(1);
        end else if (!push && pop) begin
            count_nxt = fifo_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            tx_ready   <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_count <= count_nxt;
            tx_ready   <= (count_nxt != CNT_W'(FIFO_DEPTH));
        end
    end

    // FSM state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            baud_cnt      <= '0;
            bit_cnt       <= '0;
            shreg         <= '0;
            par_bit       <= 1'b0;
            rs232_tx      <= 1'b1;
            busy          <= 1'b0;
            send_complete <= 1'b0;
        end else begin
            state         <= state_nxt;
            baud_cnt      <= baud_nxt;
            bit_cnt       <= bit_nxt;
            shreg         <= shreg_nxt;
            par_bit       <= par_nxt;
            rs232_tx      <= line_c;
            busy          <= (state != S_IDLE);
            send_complete <= done_c;
        end
    end

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        par_nxt   = par_bit;
        line_c    = 1'b1;
        done_c    = 1'b0;
        pop       = 1'b0;

        case (state)
            S_IDLE: begin
                pop = (fifo_count != '0);
            end
            S_START: begin
                line_c = 1'b0;
                if (baud_end) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = S_DATA;
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            S_DATA: begin
                line_c = shreg[0];
                if (baud_end) begin
                    baud_nxt  = '0;
                    shreg_nxt = {1'b0, shreg[DATA_BITS-1:1]};
                    if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                        bit_nxt   = '0;
                        state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_nxt = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            S_PARITY: begin
                line_c = par_bit;
                if (baud_end) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = S_STOP;
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_nxt = '0;
                    if (bit_cnt == BIT_W'(STOP_BITS - 1)) begin
                        done_c    = 1'b1;
                        bit_nxt   = '0;
                        state_nxt = S_IDLE;
                        pop       = (fifo_count != '0);
                    end else begin
                        bit_nxt = bit_cnt + BIT_W'(1);
                    end
                end else begin
                    baud_nxt = baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // A pop always launches a new frame, from IDLE or straight out of the last stop bit.
        if (pop) begin
            shreg_nxt = rd_data;
            par_nxt   = (PARITY == 1) ? ~(^rd_data) : (^rd_data);
            baud_nxt  = '0;
            bit_nxt   = '0;
            state_nxt = S_START;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four framings (8N1, 8E1, 8O1, 7O2) decoded by line monitors
// against a scoreboard of expected frames built when words are accepted.
module tb_uart_tx_fifo;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din  [4];
    logic       vld  [4];
    logic       rdy  [4];
    logic       line [4];
    logic       bsy  [4];
    logic       sc   [4];
    logic [4:0] cnt  [4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u0 (
        .clk(clk), .rst_n(rst_n), .tx_data(din[0]), .tx_valid(vld[0]), .tx_ready(rdy[0]),
        .rs232_tx(line[0]), .busy(bsy[0]), .send_complete(sc[0]), .fifo_count(cnt[0]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u1 (
        .clk(clk), .rst_n(rst_n), .tx_data(din[1]), .tx_valid(vld[1]), .tx_ready(rdy[1]),
        .rs232_tx(line[1]), .busy(bsy[1]), .send_complete(sc[1]), .fifo_count(cnt[1]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u2 (
        .clk(clk), .rst_n(rst_n), .tx_data(din[2]), .tx_valid(vld[2]), .tx_ready(rdy[2]),
        .rs232_tx(line[2]), .busy(bsy[2]), .send_complete(sc[2]), .fifo_count(cnt[2]));
    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(16)) u3 (
        .clk(clk), .rst_n(rst_n), .tx_data(din[3][6:0]), .tx_valid(vld[3]), .tx_ready(rdy[3]),
        .rs232_tx(line[3]), .busy(bsy[3]), .send_complete(sc[3]), .fifo_count(cnt[3]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Expected line bits, index 0 = start bit; positions past the frame read as idle 1s.
    function automatic logic [11:0] frame_of(input logic [7:0] d, input int nb, input int pm);
        logic [11:0] f;
        logic        p;
        f    = '1;
        f[0] = 1'b0;
        p    = 1'b0;
        for (int i = 0; i < nb; i++) begin
            f[1+i] = d[i];
            p      = p ^ d[i];
        end
        if (pm == 1) f[1+nb] = ~p;
        if (pm == 2) f[1+nb] = p;
        return f;
    endfunction

    for (genvar g = 0; g < 4; g++) begin : gm
        localparam int NB = (g == 3) ? 7 : 8;
        localparam int PM = (g == 0) ? 0 : ((g == 1) ? 2 : 1);
        localparam int NS = (g == 3) ? 2 : 1;
        localparam int FL = 1 + NB + ((PM != 0) ? 1 : 0) + NS;

        logic [11:0] q[$];
        int   frames_rx = 0;
        int   b2b       = 0;
        int   acc       = 0;
        logic last_par  = 1'b0;
        bit   idle_bad  = 1'b0;

        always @(posedge clk) begin
            if (rst_n && vld[g] && rdy[g]) begin
                q.push_back(frame_of(din[g], NB, PM));
                acc++;
            end
        end

        initial begin : mon
            int          cyc;
            logic [11:0] rb;
            logic [11:0] e;
            bit          bad;
            bit          ab;
            bit          ended;
            ended = 1'b0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    ended = 1'b0;
                end else if (line[g] === 1'b0) begin
                    if (ended) b2b++;
                    ended = 1'b0;
                    cyc   = 1;
                    rb    = '1;
                    bad   = 1'b0;
                    ab    = 1'b0;
                    forever begin
                        if (!rst_n) begin
                            ab = 1'b1;
                            break;
                        end
                        if ((cyc - 1) % CPB == 0) rb[(cyc-1)/CPB] = line[g];
                        else if (line[g] !== rb[(cyc-1)/CPB]) bad = 1'b1;
                        if (sc[g] !== (cyc == FL * CPB)) bad = 1'b1;
                        if (bsy[g] !== 1'b1) bad = 1'b1;
                        if (cyc == FL * CPB) break;
                        @(negedge clk);
                        cyc++;
                    end
                    if (!ab) begin
                        check($sformatf("frame_timing%0d", g), 32'(bad), 0);
                        check($sformatf("sb_nonempty%0d", g), 32'(q.size() > 0), 1);
                        if (q.size() > 0) begin
                            e = q.pop_front();
                            check($sformatf("frame_bits%0d", g), 32'(rb), 32'(e));
                        end
                        frames_rx++;
                        last_par = rb[1+NB];
                        ended    = 1'b1;
                    end
                end else begin
                    if (sc[g] !== 1'b0 || bsy[g] !== 1'b0) idle_bad = 1'b1;
                    ended = 1'b0;
                end
            end
        end
    end

    typedef struct {
        logic [7:0] data;
        logic       par_e8;
        logic       par_o8;
        logic       par_o7;
    } vec_t;

    vec_t vecs [6];
    int   f_before [4];
    int   a_before;
    int   b_before;
    bit   line_bad;

    initial begin
        vecs[0] = '{8'h55, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{8'hA7, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{8'h00, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{8'h3C, 1'b0, 1'b1, 1'b1};

        rst_n = 1'b0;
        for (int g = 0; g < 4; g++) begin
            din[g] = '0;
            vld[g] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int g = 0; g < 4; g++)
            check($sformatf("reset_state%0d", g),
                  32'({line[g], rdy[g], bsy[g], sc[g], cnt[g]}), 32'({1'b1, 1'b1, 1'b0, 1'b0, 5'd0}));
        rst_n = 1'b1;

        // Latency: word accepted at edge N, start bit appears at edge N+2.
        @(negedge clk);
        din[0] = 8'h55;
        vld[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld[0] = 1'b0;
        check("lat_n0_line", 32'(line[0]), 1);
        check("lat_n0_count", 32'(cnt[0]), 1);
        @(negedge clk);
        check("lat_n1_line", 32'({line[0], bsy[0]}), 32'(2'b10));
        @(negedge clk);
        check("lat_n2_line", 32'({line[0], bsy[0]}), 32'(2'b01));
        repeat (50) @(negedge clk);
        check("lat_frames", 32'(gm[0].frames_rx), 1);

        // Table: same word into all four framings, parity bit compared against hand values.
        for (int v = 0; v < 6; v++) begin
            f_before[0] = gm[0].frames_rx;
            f_before[1] = gm[1].frames_rx;
            f_before[2] = gm[2].frames_rx;
            f_before[3] = gm[3].frames_rx;
            for (int g = 0; g < 4; g++) begin
                din[g] = vecs[v].data;
                vld[g] = 1'b1;
            end
            @(negedge clk);
            for (int g = 0; g < 4; g++) vld[g] = 1'b0;
            repeat (52) @(negedge clk);
            check($sformatf("tbl%0d_frames", v),
                  32'((gm[0].frames_rx - f_before[0]) + (gm[1].frames_rx - f_before[1]) +
                      (gm[2].frames_rx - f_before[2]) + (gm[3].frames_rx - f_before[3])), 4);
            check($sformatf("tbl%0d_par_even8", v), 32'(gm[1].last_par), 32'(vecs[v].par_e8));
            check($sformatf("tbl%0d_par_odd8", v), 32'(gm[2].last_par), 32'(vecs[v].par_o8));
            check($sformatf("tbl%0d_par_odd7", v), 32'(gm[3].last_par), 32'(vecs[v].par_o7));
        end

        // FIFO full: hold valid for 20 cycles, 17 words fit.
        a_before = gm[0].acc;
        b_before = gm[0].b2b;
        vld[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            din[0] = 8'(8'h30 + k);
            @(negedge clk);
        end
        vld[0] = 1'b0;
        check("full_accepted", 32'(gm[0].acc - a_before), 17);
        check("full_ready", 32'(rdy[0]), 0);
        check("full_count", 32'(cnt[0]), 16);
        for (int i = 0; i < 900 && gm[0].q.size() != 0; i++) @(negedge clk);
        check("full_drained", 32'(gm[0].q.size()), 0);
        check("full_back_to_back", 32'(gm[0].b2b - b_before), 16);
        repeat (5) @(negedge clk);

        // Push in the same cycle as the end-of-frame pop with 5 queued.
        vld[0] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            din[0] = 8'(8'h90 + k);
            @(negedge clk);
        end
        vld[0] = 1'b0;
        for (int i = 0; i < 200 && sc[0] !== 1'b1; i++) @(negedge clk);
        check("pp_sc_seen", 32'(sc[0]), 1);
        din[0] = 8'hE1;
        vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        check("pp_frame2_start", 32'({line[0], cnt[0]}), 32'({1'b0, 5'd5}));
        repeat (38) @(negedge clk);
        check("pp_count_before", 32'(cnt[0]), 5);
        din[0] = 8'hE2;
        vld[0] = 1'b1;
        @(negedge clk);
        vld[0] = 1'b0;
        check("pp_count_after", 32'({sc[0], cnt[0]}), 32'({1'b1, 5'd5}));
        for (int i = 0; i < 400 && gm[0].q.size() != 0; i++) @(negedge clk);
        check("pp_drained", 32'(gm[0].q.size()), 0);
        repeat (5) @(negedge clk);

        // Reset during data bit 3 with 3 words queued.
        vld[0] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            din[0] = 8'(8'hC0 + k);
            @(negedge clk);
        end
        vld[0] = 1'b0;
        repeat (16) @(negedge clk);
        f_before[0] = gm[0].frames_rx;
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", 32'({line[0], bsy[0], rdy[0], sc[0], cnt[0]}),
              32'({1'b1, 1'b0, 1'b1, 1'b0, 5'd0}));
        gm[0].q.delete();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        line_bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (line[0] !== 1'b1 || sc[0] !== 1'b0) line_bad = 1'b1;
        end
        check("rst_line_idle", 32'(line_bad), 0);
        check("rst_no_frames", 32'(gm[0].frames_rx - f_before[0]), 0);

        check("idle_outputs",
              32'({gm[0].idle_bad, gm[1].idle_bad, gm[2].idle_bad, gm[3].idle_bad}), 0);
        check("sb_all_empty",
              32'(gm[0].q.size() + gm[1].q.size() + gm[2].q.size() + gm[3].q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised RS-232 transmitter, the next generation of our fixed 8N1 transmitter. It has an internal baud counter, so no external `clk_bps` or `bps_start` is needed. It supports configurable data width, parity and stop bits, and buffers words in a FIFO behind a valid/ready handshake. It sits between the frame/packet logic and the `rs232_tx` pin, and streams back-to-back frames with no idle gap while data is queued.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per serial bit (50 MHz / 115200); legal range ≥ 2.
- `DATA_BITS`, 8: data bits per frame; legal range 5..9.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 16: power of two, ≥ 2.
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `tx_data`  in  DATA_BITS  word to send.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  FIFO can accept a word; equals !full.
- `rs232_tx`  out  1  serial line, idle high.
- `busy`  out  1  a frame is on the line.
- `send_complete`  out  1  one-cycle pulse at the end of the last stop bit of every frame.
- `fifo_count`  out  clog2(FIFO_DEPTH)+1  number of words queued (not including the frame in flight).

## Operation
- Reset values: `rs232_tx`=1, `tx_ready`=1, `busy`=0, `send_complete`=0, `fifo_count`=0, FSM=IDLE.
- Reset asserted mid-frame:
  - line goes high immediately;
  - FIFO is emptied;
  - the partial frame is abandoned and no `send_complete` is issued.
- Write handshake:
  - a word is pushed on a rising edge with `tx_valid` && `tx_ready`.
  - `tx_valid` with `tx_ready`=0 is ignored; the word is dropped unless the source holds it.
- Simultaneous push and pop: `fifo_count` is unchanged.
- A push to a full FIFO never occurs, because `tx_ready` is 0.
- FSM states: IDLE → START → DATA → PARITY (skipped when `PARITY`=0) → STOP → IDLE or START.
- IDLE:
  - if FIFO is non-empty, pop the word into the shift register;
  - drive `rs232_tx`=0 and go to START.
- START: 1 bit of 0.
- DATA: `DATA_BITS` bits, LSB first.
- PARITY: 1 bit.
  - Odd: total ones over data + parity is odd.
  - Even: total ones over data + parity is even.
- STOP: `STOP_BITS` bits of 1.
- End of the last stop bit:
  - pulse `send_complete`;
  - if FIFO is non-empty, pop and enter START in the same cycle (no idle gap);
  - otherwise go to IDLE.
- Frame length = 1 + DATA_BITS + (PARITY≠0) + STOP_BITS bits.
- Baud counter:
  - counts 0..CLKS_PER_BIT−1;
  - reloads to 0 at every bit boundary and on frame start;
  - free from any external strobe.
- `busy`: high from the first cycle of START through the last cycle of the final stop bit; low in IDLE.
- `rs232_tx` is driven from a flop only (glitch-free).

## Timing
- Latency: word pushed at edge N with FIFO empty and FSM in IDLE → `rs232_tx` falls at edge N+2.
- Every bit, including each stop bit, lasts exactly `CLKS_PER_BIT` cycles.
- `send_complete`: high for exactly one cycle, the last cycle of the final stop bit.
- Back-to-back frames: the next start bit begins on the edge directly after that cycle.
- `tx_ready` and `fifo_count` update on the edge after a push or pop.
- A pop frees a slot: `tx_ready` rises on the next edge.

## Test plan
- **8N1 word.** `CLKS_PER_BIT`=4, 8N1, push 0x55.
  - Line: 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles.
  - Start bit falls at edge N+2.
  - `send_complete` pulses once at cycle 40 of the frame.
- **Even parity.** 8E1, push 0xA7 (5 ones) → parity bit = 1. Odd parity with the same data → parity bit = 0.
- **2 stop bits.** 7O2, push 0x00 → parity 1; stop is high for 8 cycles; frame is 11 bits = 44 cycles.
- **FIFO full.** `FIFO_DEPTH`=16, hold `tx_valid` for 20 cycles during a frame.
  - Exactly 17 words are accepted (1 in flight + 16 queued).
  - `tx_ready`=0 with `fifo_count`=16.
  - All 17 words are sent in order, contiguously, with no idle cycles between frames.
- **Reset mid-frame.** Assert `rst_n`=0 during data bit 3 with 3 words queued.
  - `rs232_tx`=1 immediately; `fifo_count`=0; `busy`=0.
  - No `send_complete`.
  - After release, the line stays idle.
- **Push and pop in the same cycle.** Push in the same cycle as a pop at frame end with `fifo_count`=5 → `fifo_count` stays 5.
